// File: rtl/bsearch_guess_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bsearch_guess_ctrl_pkg
// Description : Shared definitions for the binary-search guess controller.
//               Holds the FSM state encoding and the one-hot legal codes for
//               the comparator result vector {eq,gt,lt}.
// Revision    : 1.0 - initial release
// ============================================================================
package bsearch_guess_ctrl_pkg;

  // 2-bit state encoding; code 3 is unused and recovers to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Legal comparator result codes, ordered {eq,gt,lt}.
  localparam logic [2:0] CODE_EQ = 3'b100;
  localparam logic [2:0] CODE_GT = 3'b010;
  localparam logic [2:0] CODE_LT = 3'b001;

  // True when exactly one of the three comparator outputs is set.
  function automatic logic is_legal_code(input logic [2:0] code);
    return (code == CODE_EQ) || (code == CODE_GT) || (code == CODE_LT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bsearch_guess_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : bsearch_guess_ctrl
// Description : Binary-search controller that drives the A input of an
//               external W-bit magnitude comparator and narrows [lo,hi]
//               from the fed-back eq/gt/lt until the secret is hit or the
//               range is exhausted.
// Ports       : clk   - rising-edge clock
//               rst   - synchronous active-high reset
//               start - begin a search (accepted in IDLE and DONE only)
//               eq/gt/lt - comparator results for the current guess
//               guess - registered guess, wired to comparator A
//               busy  - high while comparing
//               done  - high in DONE, held until the next start
//               found - valid with done: the secret equals guess
//               err   - valid with done: an illegal comparator code was seen
//               steps - compares performed in the current/last search
// Revision    : 1.0 - initial release
// ============================================================================
module bsearch_guess_ctrl
  import bsearch_guess_ctrl_pkg::*;
#(
  parameter int W  = 3,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          eq,
  input  logic          gt,
  input  logic          lt,
  output logic [W-1:0]  guess,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          err,
  output logic [CW-1:0] steps
);

  localparam logic [W-1:0]  MAX_V      = '1;
  localparam logic [W-1:0]  INIT_GUESS = MAX_V >> 1;  // mid(0, 2^W-1)
  localparam logic [CW-1:0] STEPS_MAX  = '1;

  state_t        state;
  logic [W-1:0]  lo;
  logic [W-1:0]  hi;

  logic [2:0]    code;
  logic [W-1:0]  guess_dec;
  logic [W-1:0]  guess_inc;
  logic [W:0]    sum_gt;
  logic [W:0]    sum_lt;
  logic [W-1:0]  mid_gt;
  logic [W-1:0]  mid_lt;
  logic [CW-1:0] steps_nx;

  // Midpoints for the next guess. Sums are one bit wider so that the top
  // of the range cannot wrap before the shift. The decrement/increment only
  // feed these when guess is strictly inside the range, so they never wrap.
  always_comb begin
    code      = {eq, gt, lt};
    guess_dec = guess - W'(1);
    guess_inc = guess + W'(1);
    sum_gt    = {1'b0, lo} + {1'b0, guess_dec};
    sum_lt    = {1'b0, guess_inc} + {1'b0, hi};
    mid_gt    = W'(sum_gt >> 1);
    mid_lt    = W'(sum_lt >> 1);
    steps_nx  = (steps == STEPS_MAX) ? steps : steps + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      lo    <= '0;
      hi    <= MAX_V;
      guess <= '0;
      steps <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      found <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_CMP;
            lo    <= '0;
            hi    <= MAX_V;
            guess <= INIT_GUESS;
            steps <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            found <= 1'b0;
            err   <= 1'b0;
          end
        end

        ST_CMP: begin
          steps <= steps_nx;
          if (!is_legal_code(code)) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            err   <= 1'b1;
            found <= 1'b0;
          end else if (code == CODE_EQ) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            found <= 1'b1;
          end else if (code == CODE_GT) begin
            if (guess == lo) begin
              // Nothing left below the guess: range exhausted.
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              found <= 1'b0;
            end else begin
              hi    <= guess_dec;
              guess <= mid_gt;
            end
          end else begin
            if (guess == hi) begin
              // Nothing left above the guess: range exhausted.
              state <= ST_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              found <= 1'b0;
            end else begin
              lo    <= guess_inc;
              guess <= mid_lt;
            end
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bsearch_guess_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_bsearch_guess_ctrl
// Description : Self-checking bench pairing the controller with a 3-bit
//               magnitude comparator model. Expected guess sequences are
//               queued at start and popped each busy cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bsearch_guess_ctrl;

  localparam int W  = 3;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          eq, gt, lt;
  logic [W-1:0]  guess;
  logic          busy, done, found, err;
  logic [CW-1:0] steps;

  logic [W-1:0]  secret;
  logic          bypass;
  logic [2:0]    force_code;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] exp_q[$];

  always #5 clk = ~clk;

  // Comparator beside the controller (A=guess, B=secret), bypassable.
  assign eq = bypass ? force_code[2] : (guess == secret);
  assign gt = bypass ? force_code[1] : (guess >  secret);
  assign lt = bypass ? force_code[0] : (guess <  secret);

  bsearch_guess_ctrl #(.W(W), .CW(CW)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .eq    (eq),
    .gt    (gt),
    .lt    (lt),
    .guess (guess),
    .busy  (busy),
    .done  (done),
    .found (found),
    .err   (err),
    .steps (steps)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference binary search over [0,7]; fills exp_q, returns compare count.
  function automatic int build_expected(input int s);
    int lo = 0;
    int hi = 7;
    int g;
    int n = 0;
    exp_q.delete();
    forever begin
      g = (lo + hi) / 2;
      exp_q.push_back(W'(g));
      n++;
      if (g == s) break;
      if (g > s) begin
        if (g == lo) break;
        hi = g - 1;
      end else begin
        if (g == hi) break;
        lo = g + 1;
      end
    end
    return n;
  endfunction

  // Start a search with exp_q preloaded; pop/compare every busy cycle.
  task automatic run_search(input string name, input int exp_steps, input logic exp_found);
    int cyc = 0;
    logic [W-1:0] e;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (busy && cyc < 10) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL %s extra_guess: got %0d, required no further guess", name, guess);
      end else begin
        e = exp_q.pop_front();
        if (guess !== e) begin
          n_bad++;
          $display("FAIL %s guess[%0d]: got %0d, required %0d", name, cyc, guess, e);
        end
      end
      tick();
      cyc++;
    end
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done: got done=%b busy=%b, required done=1 busy=0", name, done, busy);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s missing_guesses: got %0d unconsumed, required 0", name, exp_q.size());
    end
    n_cmp++;
    if (found !== exp_found || err !== 1'b0 || steps !== CW'(exp_steps)) begin
      n_bad++;
      $display("FAIL %s result: got found=%b err=%b steps=%0d, required found=%b err=0 steps=%0d",
               name, found, err, steps, exp_found, exp_steps);
    end
    n_cmp++;
    if (exp_found && guess !== secret) begin
      n_bad++;
      $display("FAIL %s final_guess: got %0d, required %0d", name, guess, secret);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; bypass = 1'b0; force_code = 3'b000; secret = '0;
    tick(); tick();
    rst = 1'b0;
    n_cmp++;
    if ({guess, busy, done, found, err, steps} !== '0) begin
      n_bad++;
      $display("FAIL reset: got guess=%0d busy=%b done=%b found=%b err=%b steps=%0d, required all 0",
               guess, busy, done, found, err, steps);
    end
  endtask

  task automatic test_secret7();
    secret = 3'd7;
    exp_q.delete();
    exp_q.push_back(3'd3); exp_q.push_back(3'd5); exp_q.push_back(3'd6); exp_q.push_back(3'd7);
    run_search("secret7", 4, 1'b1);
  endtask

  task automatic test_secret0();
    secret = 3'd0;
    exp_q.delete();
    exp_q.push_back(3'd3); exp_q.push_back(3'd1); exp_q.push_back(3'd0);
    run_search("secret0", 3, 1'b1);
  endtask

  task automatic test_exhaustive();
    int n;
    for (int s = 0; s < 8; s++) begin
      secret = W'(s);
      n = build_expected(s);
      run_search($sformatf("exh%0d", s), n, 1'b1);
      n_cmp++;
      if (n > 4) begin
        n_bad++;
        $display("FAIL exh%0d step_bound: got %0d, required <=4", s, n);
      end
    end
  endtask

  task automatic test_illegal_code();
    bypass = 1'b1; force_code = 3'b011;
    start = 1'b1; tick(); start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || guess !== 3'd3) begin
      n_bad++;
      $display("FAIL illegal_cmp_entry: got busy=%b guess=%0d, required busy=1 guess=3", busy, guess);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || err !== 1'b1 || found !== 1'b0 || steps !== 3'd1 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL illegal_code: got done=%b err=%b found=%b steps=%0d busy=%b, required 1 1 0 1 0",
               done, err, found, steps, busy);
    end
    bypass = 1'b0;
  endtask

  task automatic test_reset_mid_search();
    secret = 3'd6;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    n_cmp++;
    if (busy !== 1'b1 || guess !== 3'd5 || steps !== 3'd1) begin
      n_bad++;
      $display("FAIL midrst_pre: got busy=%b guess=%0d steps=%0d, required 1 5 1", busy, guess, steps);
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_cmp++;
    if ({guess, busy, done, found, err, steps} !== '0) begin
      n_bad++;
      $display("FAIL midrst_outputs: got guess=%0d busy=%b done=%b found=%b err=%b steps=%0d, required all 0",
               guess, busy, done, found, err, steps);
    end
    exp_q.delete();
    exp_q.push_back(3'd3); exp_q.push_back(3'd5); exp_q.push_back(3'd6);
    run_search("midrst_again", 3, 1'b1);
  endtask

  task automatic test_back_to_back();
    int cyc;
    secret = 3'd5;
    start = 1'b1;
    tick();
    n_cmp++;
    if (guess !== 3'd3 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_g1: got guess=%0d busy=%b, required 3 1", guess, busy);
    end
    tick();
    n_cmp++;
    if (guess !== 3'd5 || busy !== 1'b1 || steps !== 3'd1) begin
      n_bad++;
      $display("FAIL b2b_ignored_start: got guess=%0d busy=%b steps=%0d, required 5 1 1", guess, busy, steps);
    end
    tick();
    n_cmp++;
    if (done !== 1'b1 || found !== 1'b1 || steps !== 3'd2 || guess !== 3'd5) begin
      n_bad++;
      $display("FAIL b2b_done: got done=%b found=%b steps=%0d guess=%0d, required 1 1 2 5",
               done, found, steps, guess);
    end
    tick();  // start still high in DONE: restart
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0 || found !== 1'b0 || guess !== 3'd3 || steps !== 3'd0) begin
      n_bad++;
      $display("FAIL b2b_restart: got busy=%b done=%b found=%b guess=%0d steps=%0d, required 1 0 0 3 0",
               busy, done, found, guess, steps);
    end
    // Secret moves from 2 to 6 after the first compare: 3>2, then 1<6, 2<6 -> exhausted.
    start = 1'b0;
    secret = 3'd2;
    tick();
    secret = 3'd6;
    cyc = 1;
    while (!done && cyc < 6) begin
      tick();
      cyc++;
    end
    n_cmp++;
    if (done !== 1'b1 || cyc > 4) begin
      n_bad++;
      $display("FAIL moving_secret_term: got done=%b after %0d compares, required done within 4", done, cyc);
    end
    n_cmp++;
    if (found !== 1'b0 || err !== 1'b0 || steps !== 3'd3 || guess !== 3'd2) begin
      n_bad++;
      $display("FAIL moving_secret_result: got found=%b err=%b steps=%0d guess=%0d, required 0 0 3 2",
               found, err, steps, guess);
    end
  endtask

  initial begin
    test_reset();
    test_secret7();
    test_secret0();
    test_exhaustive();
    test_illegal_code();
    test_reset_mid_search();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Hard bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: got no completion, required finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
